// File: rtl/crforth_pkg.sv
// rtl/crforth_pkg.sv - shared types and constants for the Forth core
//   PHASE_W : width of the phase encoding
//   phase_t : sequencer states IDLE/PX/PY/PZ, encoded so the state register
//             can be exported directly as a phase number
package crforth_pkg;

  localparam int PHASE_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    IDLE = 2'd0,
    PX   = 2'd1,
    PY   = 2'd2,
    PZ   = 2'd3
  } phase_t;

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - wrapping counter of retired X-Y-Z triplets
//   i_CLOCK   : clock, posedge
//   i_CLEAR_N : synchronous active-low clear
//   i_INC     : increment enable
//   o_COUNT   : current count, wraps modulo 2^CNT_WIDTH
module retire_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_CLOCK,
  input  logic                 i_CLEAR_N,
  input  logic                 i_INC,
  output logic [CNT_WIDTH-1:0] o_COUNT
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge i_CLOCK) begin
    if (!i_CLEAR_N) begin
      count <= '0;
    end else if (i_INC) begin
      count <= count + 1'b1;
    end
  end

  assign o_COUNT = count;

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - three-phase X/Y/Z enable sequencer with run/step/stall
//   i_CLOCK   : sole clock
//   i_RESET_N : synchronous active-low reset
//   i_RUN     : level, free-run triplets back to back
//   i_STEP    : pulse, one triplet while halted
//   i_STALL   : level, hold current phase and suppress its strobe
//   o_CYCLEX/o_CYCLEY/o_CYCLEZ : one-clock phase enable strobes
//   o_PHASE   : state encoding (0 IDLE, 1 X, 2 Y, 3 Z)
//   o_IDLE    : sequencer is in IDLE
//   o_DONE    : strobe on the clock in which Z completes
//   o_COUNT   : number of completed triplets
module phase_sequencer
  import crforth_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_CLOCK,
  input  logic                 i_RESET_N,
  input  logic                 i_RUN,
  input  logic                 i_STEP,
  input  logic                 i_STALL,
  output logic                 o_CYCLEX,
  output logic                 o_CYCLEY,
  output logic                 o_CYCLEZ,
  output logic [PHASE_W-1:0]   o_PHASE,
  output logic                 o_IDLE,
  output logic                 o_DONE,
  output logic [CNT_WIDTH-1:0] o_COUNT
);

  phase_t state;
  phase_t next_state;
  logic   step_mode;
  logic   next_step_mode;
  logic   retire;
  logic   strobe_ok;

  always_ff @(posedge i_CLOCK) begin
    if (!i_RESET_N) begin
      state     <= IDLE;
      step_mode <= 1'b0;
    end else begin
      state     <= next_state;
      step_mode <= next_step_mode;
    end
  end

  always_comb begin
    next_state     = state;
    next_step_mode = step_mode;
    retire         = 1'b0;
    case (state)
      IDLE: begin
        // Stall is deliberately ignored here; RUN outranks STEP.
        if (i_RUN) begin
          next_state     = PX;
          next_step_mode = 1'b0;
        end else if (i_STEP) begin
          next_state     = PX;
          next_step_mode = 1'b1;
        end
      end
      PX: begin
        if (!i_STALL) next_state = PY;
      end
      PY: begin
        if (!i_STALL) next_state = PZ;
      end
      PZ: begin
        if (!i_STALL) begin
          retire         = 1'b1;
          next_step_mode = 1'b0;
          // A step triplet always returns to IDLE even if RUN rose meanwhile.
          if (i_RUN && !step_mode) begin
            next_state = PX;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes are gated by reset so they drop in the cycle before the reset edge.
  assign strobe_ok = i_RESET_N & ~i_STALL;
  assign o_CYCLEX  = (state == PX) & strobe_ok;
  assign o_CYCLEY  = (state == PY) & strobe_ok;
  assign o_CYCLEZ  = (state == PZ) & strobe_ok;
  assign o_DONE    = o_CYCLEZ;

  assign o_PHASE   = PHASE_W'(state);
  assign o_IDLE    = (state == IDLE);

  retire_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_retire_counter (
    .i_CLOCK   (i_CLOCK),
    .i_CLEAR_N (i_RESET_N),
    .i_INC     (retire),
    .o_COUNT   (o_COUNT)
  );

endmodule
